// File: rtl/regfile_dump_unit_if.sv
// Dump channel between the register-dump engine and its consumer (host link,
// UART bridge or checker). The engine is the master: it presents one register
// per beat and holds it until the consumer raises dump_ready.
interface regfile_dump_unit_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);

  logic              dump_valid;
  logic              dump_ready;
  logic [ADDR_W-1:0] dump_idx;
  logic [DATA_W-1:0] dump_data;

  modport master (
    output dump_valid,
    output dump_idx,
    output dump_data,
    input  dump_ready
  );

  modport slave (
    input  dump_valid,
    input  dump_idx,
    input  dump_data,
    output dump_ready
  );

endinterface

// File: rtl/regfile_dump_unit.sv
// Register-dump engine for processor bring-up.
// After a start request the processor is allowed to run for a programmed
// number of cycles. The engine then takes over regfile read port A and walks
// every register index in order. Each value is captured and offered on the
// dump channel, and the engine waits for the consumer before moving on.
module regfile_dump_unit #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int CYC_W    = 14
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [CYC_W-1:0]  run_cycles,
  output logic              test_mode,
  output logic [ADDR_W-1:0] test_reg,
  input  logic [DATA_W-1:0] reg_data,
  output logic [CYC_W-1:0]  cycle_count,
  output logic              busy,
  output logic              done,
  regfile_dump_unit_if.master dump
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_SCAN,
    S_SEND,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] idx_q;
  logic [CYC_W-1:0]  run_lat_q;
  logic [CYC_W-1:0]  cycle_count_q;
  logic [CYC_W-1:0]  cycle_next;
  logic              dump_valid_q;
  logic [ADDR_W-1:0] dump_idx_q;
  logic [DATA_W-1:0] dump_data_q;
  logic              start_accept;
  logic              handshake;
  logic              last_reg;

  // A start request is only honoured while the engine is not busy, so a
  // stray pulse during a dump cannot corrupt the latched run length.
  assign start_accept = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign handshake    = dump_valid_q && dump.dump_ready;
  assign last_reg     = (idx_q == LAST_IDX);
  assign cycle_next   = cycle_count_q + 1'b1;

  // State register; reset aborts any run or dump in progress.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode: run phase ends on the edge that brings the counter
  // up to the latched run length, and each register costs a SCAN plus at
  // least one SEND cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = (run_cycles != '0) ? S_RUN : S_SCAN;
        end
      end
      S_RUN: begin
        if (cycle_next == run_lat_q) begin
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        state_d = S_SEND;
      end
      S_SEND: begin
        if (handshake) begin
          state_d = last_reg ? S_DONE : S_SCAN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Datapath: run counter, register index and the captured dump beat.
  // The index never advances past the last register, and the run counter
  // stops once it reaches the latched run length, so neither can wrap.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx_q         <= '0;
      run_lat_q     <= '0;
      cycle_count_q <= '0;
      dump_valid_q  <= 1'b0;
      dump_idx_q    <= '0;
      dump_data_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_accept) begin
            cycle_count_q <= '0;
            run_lat_q     <= run_cycles;
            idx_q         <= '0;
          end
        end
        S_RUN: begin
          cycle_count_q <= cycle_next;
        end
        S_SCAN: begin
          dump_data_q  <= reg_data;
          dump_idx_q   <= idx_q;
          dump_valid_q <= 1'b1;
        end
        S_SEND: begin
          if (handshake) begin
            dump_valid_q <= 1'b0;
            if (!last_reg) begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        default: begin
          dump_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Port A stays under engine control from the first scan until the next
  // start, so the regfile index is still visible while parked in DONE.
  always_comb begin
    test_mode = (state_q == S_SCAN) || (state_q == S_SEND) || (state_q == S_DONE);
    test_reg  = idx_q;
    busy      = (state_q == S_RUN) || (state_q == S_SCAN) || (state_q == S_SEND);
    done      = (state_q == S_DONE);
  end

  assign cycle_count    = cycle_count_q;
  assign dump.dump_valid = dump_valid_q;
  assign dump.dump_idx   = dump_idx_q;
  assign dump.dump_data  = dump_data_q;

endmodule

// File: tb/tb_regfile_dump_unit.sv
// Directed bench for the register-dump engine. A behavioural regfile holds
// r_i = 3*i and answers port A combinationally from test_reg.
module tb_regfile_dump_unit;

  logic        clock;
  logic        reset;
  logic        start;
  logic [13:0] run_cycles;
  logic        test_mode;
  logic [4:0]  test_reg;
  logic [31:0] reg_data;
  logic [13:0] cycle_count;
  logic        busy;
  logic        done;
  logic [31:0] regfile [32];

  int vectors;
  int miscompares;

  regfile_dump_unit_if #(.ADDR_W(5), .DATA_W(32)) dump_if ();

  regfile_dump_unit #(
    .NUM_REGS(32),
    .ADDR_W(5),
    .DATA_W(32),
    .CYC_W(14)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .run_cycles  (run_cycles),
    .test_mode   (test_mode),
    .test_reg    (test_reg),
    .reg_data    (reg_data),
    .cycle_count (cycle_count),
    .busy        (busy),
    .done        (done),
    .dump        (dump_if.master)
  );

  // Free-running clock, posedge at 5, 15, 25, ...
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Behavioural regfile read port A.
  always_comb begin
    reg_data = regfile[test_reg];
  end

  task automatic do_reset();
    reset              = 1'b1;
    start              = 1'b0;
    run_cycles         = '0;
    dump_if.dump_ready = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the start edge.
  task automatic pulse_start(input logic [13:0] cyc);
    start      = 1'b1;
    run_cycles = cyc;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset              = 1'b1;
    start              = 1'b0;
    run_cycles         = '0;
    dump_if.dump_ready = 1'b1;
    #3;
    vectors++;
    if ({test_mode, test_reg, cycle_count, busy, done, dump_if.dump_valid,
         dump_if.dump_idx, dump_if.dump_data} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs got tm=%b treg=%0d cc=%0d busy=%b done=%b v=%b idx=%0d data=%0h exp all 0",
               test_mode, test_reg, cycle_count, busy, done, dump_if.dump_valid,
               dump_if.dump_idx, dump_if.dump_data);
    end
    @(negedge clock);
    reset = 1'b0;
    pulse_start(14'd3);
    vectors++;
    if (busy !== 1'b1 || cycle_count !== 14'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_start got busy=%b cc=%0d exp busy=1 cc=0", busy, cycle_count);
    end
    for (int e = 1; e <= 3; e++) begin
      @(negedge clock);
      vectors++;
      if (cycle_count !== 14'(e)) begin
        miscompares++;
        $display("[TB] FAIL reset_run_count edge %0d got %0d exp %0d", e, cycle_count, e);
      end
    end
    vectors++;
    if (test_mode !== 1'b1 || busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset_scan_entry got tm=%b busy=%b exp 1 1", test_mode, busy);
    end
  endtask

  task automatic test_full_dump();
    logic        exp_valid;
    logic [4:0]  exp_idx;
    do_reset();
    pulse_start(14'd3);
    for (int e = 1; e <= 67; e++) begin
      @(negedge clock);
      exp_valid = (e >= 4) && (e <= 66) && (e % 2 == 0);
      exp_idx   = 5'((e - 4) / 2);
      vectors++;
      if (dump_if.dump_valid !== exp_valid || done !== (e == 67) ||
          cycle_count !== 14'((e < 3) ? e : 3)) begin
        miscompares++;
        $display("[TB] FAIL full_ctrl edge %0d got v=%b done=%b cc=%0d exp v=%b done=%b cc=%0d",
                 e, dump_if.dump_valid, done, cycle_count, exp_valid, (e == 67), (e < 3) ? e : 3);
      end
      if (exp_valid) begin
        vectors++;
        if (dump_if.dump_idx !== exp_idx || dump_if.dump_data !== 32'(3 * exp_idx)) begin
          miscompares++;
          $display("[TB] FAIL full_beat edge %0d got idx=%0d data=%0d exp idx=%0d data=%0d",
                   e, dump_if.dump_idx, dump_if.dump_data, exp_idx, 3 * exp_idx);
        end
      end
    end
    vectors++;
    if (busy !== 1'b0 || test_mode !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL full_done_state got busy=%b tm=%b exp busy=0 tm=1", busy, test_mode);
    end
  endtask

  task automatic test_backpressure();
    int n;
    do_reset();
    pulse_start(14'd3);
    n = 0;
    while (!(test_mode && !dump_if.dump_valid && test_reg == 5'd7) && n < 100) begin
      @(negedge clock);
      n++;
    end
    vectors++;
    if (n >= 100) begin
      miscompares++;
      $display("[TB] FAIL bp_wait_scan7 got timeout exp scan of idx 7");
    end
    dump_if.dump_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      vectors++;
      if (dump_if.dump_valid !== 1'b1 || dump_if.dump_idx !== 5'd7 ||
          dump_if.dump_data !== 32'd21 || test_reg !== 5'd7) begin
        miscompares++;
        $display("[TB] FAIL bp_hold cycle %0d got v=%b idx=%0d data=%0d treg=%0d exp 1 7 21 7",
                 c, dump_if.dump_valid, dump_if.dump_idx, dump_if.dump_data, test_reg);
      end
    end
    dump_if.dump_ready = 1'b1;
    @(negedge clock);
    vectors++;
    if (dump_if.dump_valid !== 1'b0 || test_reg !== 5'd8) begin
      miscompares++;
      $display("[TB] FAIL bp_release got v=%b treg=%0d exp v=0 treg=8", dump_if.dump_valid, test_reg);
    end
    @(negedge clock);
    vectors++;
    if (dump_if.dump_valid !== 1'b1 || dump_if.dump_idx !== 5'd8 || dump_if.dump_data !== 32'd24) begin
      miscompares++;
      $display("[TB] FAIL bp_resume got v=%b idx=%0d data=%0d exp 1 8 24",
               dump_if.dump_valid, dump_if.dump_idx, dump_if.dump_data);
    end
  endtask

  task automatic test_zero_run();
    do_reset();
    pulse_start(14'd0);
    vectors++;
    if (busy !== 1'b1 || test_mode !== 1'b1 || test_reg !== 5'd0 ||
        cycle_count !== 14'd0 || dump_if.dump_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL zero_scan got busy=%b tm=%b treg=%0d cc=%0d v=%b exp 1 1 0 0 0",
               busy, test_mode, test_reg, cycle_count, dump_if.dump_valid);
    end
    @(negedge clock);
    vectors++;
    if (dump_if.dump_valid !== 1'b1 || dump_if.dump_idx !== 5'd0 || dump_if.dump_data !== 32'd0) begin
      miscompares++;
      $display("[TB] FAIL zero_first_beat got v=%b idx=%0d data=%0d exp 1 0 0",
               dump_if.dump_valid, dump_if.dump_idx, dump_if.dump_data);
    end
  endtask

  task automatic test_start_ignored_and_restart();
    int n;
    do_reset();
    pulse_start(14'd5);
    @(negedge clock);
    @(negedge clock);
    start      = 1'b1;
    run_cycles = 14'd1;
    @(negedge clock);
    start = 1'b0;
    vectors++;
    if (cycle_count !== 14'd3 || busy !== 1'b1 || test_mode !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL busy_start_ignored got cc=%0d busy=%b tm=%b exp 3 1 0",
               cycle_count, busy, test_mode);
    end
    @(negedge clock);
    vectors++;
    if (cycle_count !== 14'd4 || test_mode !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL busy_run_continues got cc=%0d tm=%b exp 4 0", cycle_count, test_mode);
    end
    @(negedge clock);
    vectors++;
    if (cycle_count !== 14'd5 || test_mode !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL busy_run_len got cc=%0d tm=%b exp 5 1", cycle_count, test_mode);
    end
    n = 0;
    while (!done && n < 200) begin
      @(negedge clock);
      n++;
    end
    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL restart_wait_done got done=%b exp 1", done);
    end
    pulse_start(14'd2);
    vectors++;
    if (test_mode !== 1'b0 || done !== 1'b0 || busy !== 1'b1 || cycle_count !== 14'd0) begin
      miscompares++;
      $display("[TB] FAIL restart_from_done got tm=%b done=%b busy=%b cc=%0d exp 0 0 1 0",
               test_mode, done, busy, cycle_count);
    end
    @(negedge clock);
    @(negedge clock);
    vectors++;
    if (cycle_count !== 14'd2 || test_mode !== 1'b1 || test_reg !== 5'd0) begin
      miscompares++;
      $display("[TB] FAIL restart_run got cc=%0d tm=%b treg=%0d exp 2 1 0",
               cycle_count, test_mode, test_reg);
    end
  endtask

  task automatic test_reset_mid_send();
    int n;
    do_reset();
    pulse_start(14'd1);
    n = 0;
    while (!(test_mode && !dump_if.dump_valid && test_reg == 5'd12) && n < 100) begin
      @(negedge clock);
      n++;
    end
    dump_if.dump_ready = 1'b0;
    @(negedge clock);
    vectors++;
    if (dump_if.dump_valid !== 1'b1 || dump_if.dump_idx !== 5'd12 || dump_if.dump_data !== 32'd36) begin
      miscompares++;
      $display("[TB] FAIL midsend_reach got v=%b idx=%0d data=%0d exp 1 12 36",
               dump_if.dump_valid, dump_if.dump_idx, dump_if.dump_data);
    end
    #2;
    reset = 1'b1;
    #1;
    vectors++;
    if (dump_if.dump_valid !== 1'b0 || test_mode !== 1'b0 || busy !== 1'b0 ||
        test_reg !== 5'd0 || dump_if.dump_idx !== 5'd0) begin
      miscompares++;
      $display("[TB] FAIL midsend_async_reset got v=%b tm=%b busy=%b treg=%0d idx=%0d exp all 0",
               dump_if.dump_valid, test_mode, busy, test_reg, dump_if.dump_idx);
    end
    @(negedge clock);
    reset              = 1'b0;
    dump_if.dump_ready = 1'b1;
    pulse_start(14'd0);
    @(negedge clock);
    vectors++;
    if (dump_if.dump_valid !== 1'b1 || dump_if.dump_idx !== 5'd0 || dump_if.dump_data !== 32'd0) begin
      miscompares++;
      $display("[TB] FAIL midsend_redump got v=%b idx=%0d data=%0d exp 1 0 0",
               dump_if.dump_valid, dump_if.dump_idx, dump_if.dump_data);
    end
  endtask

  // Scenario sequence.
  initial begin
    vectors     = 0;
    miscompares = 0;
    for (int i = 0; i < 32; i++) begin
      regfile[i] = 32'(3 * i);
    end
    test_reset();
    test_full_dump();
    test_backpressure();
    test_zero_run();
    test_start_ignored_and_restart();
    test_reset_mid_send();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
